// File: rtl/iiitb_cg_pkg.sv
// Shared definitions for the clock-gating enable generator:
// controller state encoding and default counter widths.
package iiitb_cg_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } cg_state_e;

    localparam int DEF_CNT_W  = 4;
    localparam int DEF_STAT_W = 16;

endpackage

// File: rtl/iiitb_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module iiitb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Clock-gate enable generator: drops the ICG enable after an idle interval,
// restores it on activity, and only raises ready once the gated clock is stable.
module iiitb_cg_ctrl
    import iiitb_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STAT_W      = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              act,
    input  logic              force_on,
    output logic              en,
    output logic              ready,
    output logic              sleep,
    output logic [STAT_W-1:0] gated_cnt
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             sleep_q, sleep_d;
    logic             wake;
    logic             gate_inc;

    assign wake = act | force_on;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        en_d       = en_q;
        ready_d    = ready_q;
        sleep_d    = sleep_q;
        gate_inc   = 1'b0;

        case (state_q)
            ST_RUN: begin
                en_d    = 1'b1;
                ready_d = 1'b1;
                sleep_d = 1'b0;
                // Activity on the terminal edge wins: the idle run simply restarts.
                if (wake) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = ST_DRAIN;
                    ready_d    = 1'b0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (wake) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_SLEEP;
                    en_d    = 1'b0;
                    sleep_d = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (wake) begin
                    state_d    = ST_WAKE;
                    en_d       = 1'b1;
                    sleep_d    = 1'b0;
                    wake_cnt_d = '0;
                end else begin
                    gate_inc = 1'b1;
                end
            end
            ST_WAKE: begin
                // Fixed settle time with the clock running; inputs cannot shorten it.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_RUN;
                    ready_d    = 1'b1;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                en_d    = 1'b1;
                ready_d = 1'b1;
                sleep_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            en_q       <= 1'b1;
            ready_q    <= 1'b1;
            sleep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
            sleep_q    <= sleep_d;
        end
    end

    iiitb_sat_cnt #(
        .W(STAT_W)
    ) u_gated_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (1'b0),
        .inc  (gate_inc),
        .cnt  (gated_cnt)
    );

    assign en    = en_q;
    assign ready = ready_q;
    assign sleep = sleep_q;

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Self-checking bench for iiitb_cg_ctrl: directed scenarios plus random traffic
// against a behavioural model; a 4-bit-stat instance exercises saturation.
module tb_iiitb_cg_ctrl;

    localparam int IDLE = 8;
    localparam int WAKE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        act = 1'b0;
    logic        force_on = 1'b0;
    logic        en, ready, sleep;
    logic [15:0] gated_cnt;
    logic        en_s, ready_s, sleep_s;
    logic [3:0]  gated_cnt_s;

    int total = 0;
    int bad = 0;

    // behavioural model
    logic        m_en = 1'b1, m_ready = 1'b1, m_sleep = 1'b0;
    bit          m_drain = 1'b0;
    int          m_idle_run = 0;
    int          m_wake_left = 0;
    int          m_gated = 0;
    logic [15:0] exp_g16;
    logic [3:0]  exp_g4;

    always #5 clk = ~clk;

    iiitb_cg_ctrl dut (
        .clk(clk), .reset(reset), .act(act), .force_on(force_on),
        .en(en), .ready(ready), .sleep(sleep), .gated_cnt(gated_cnt)
    );

    iiitb_cg_ctrl #(.STAT_W(4)) dut_s (
        .clk(clk), .reset(reset), .act(act), .force_on(force_on),
        .en(en_s), .ready(ready_s), .sleep(sleep_s), .gated_cnt(gated_cnt_s)
    );

    task automatic model_update();
        bit w;
        w = act | force_on;
        if (reset) begin
            m_en = 1'b1; m_ready = 1'b1; m_sleep = 1'b0; m_drain = 1'b0;
            m_idle_run = 0; m_wake_left = 0; m_gated = 0;
        end else if (m_ready) begin
            m_idle_run = w ? 0 : m_idle_run + 1;
            if (m_idle_run == IDLE) begin
                m_ready = 1'b0; m_drain = 1'b1; m_idle_run = 0;
            end
        end else if (m_drain) begin
            m_drain = 1'b0;
            if (w) m_ready = 1'b1;
            else begin m_en = 1'b0; m_sleep = 1'b1; end
        end else if (m_sleep) begin
            if (w) begin
                m_en = 1'b1; m_sleep = 1'b0; m_wake_left = WAKE;
            end else begin
                m_gated++;
            end
        end else begin
            m_wake_left--;
            if (m_wake_left == 0) m_ready = 1'b1;
        end
        exp_g16 = (m_gated > 65535) ? 16'hffff : 16'(m_gated);
        exp_g4  = (m_gated > 15) ? 4'hf : 4'(m_gated);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; act = 1'b0; force_on = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // invariant monitor: ready implies en, and ready rises only after WAKE edges of en
    bit rst_at_edge = 1'b1;
    int en_hi = 1000;
    logic ready_prev = 1'b1;
    always @(posedge clk) rst_at_edge <= reset;
    always @(negedge clk) begin
        if (rst_at_edge) en_hi = 1000;
        else if (en === 1'b1) en_hi++;
        else en_hi = 0;
        total++;
        if (ready === 1'b1 && en !== 1'b1) begin
            bad++;
            $display("FAIL inv_ready_en: ready=%b en=%b at %0t", ready, en, $time);
        end
        if (!rst_at_edge && ready === 1'b1 && ready_prev === 1'b0) begin
            total++;
            if (en_hi - 1 < WAKE) begin
                bad++;
                $display("FAIL inv_ready_rise: en high edges=%0d required>=%0d at %0t", en_hi - 1, WAKE, $time);
            end
        end
        ready_prev = ready;
    end

    task automatic test_reset();
        reset = 1'b1;
        step();
        total++;
        if ({en, ready, sleep, gated_cnt} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL reset: en/ready/sleep/cnt=%b%b%b/%0d required 110/0", en, ready, sleep, gated_cnt);
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_idle_to_sleep();
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            step();
            total++;
            if ({en, ready} !== 2'b11) begin
                bad++;
                $display("FAIL idle_run edge %0d: en=%b ready=%b required 1 1", i, en, ready);
            end
        end
        step();
        total++;
        if ({en, ready, sleep} !== 3'b100) begin
            bad++;
            $display("FAIL drain: en/ready/sleep=%b%b%b required 100", en, ready, sleep);
        end
        step();
        total++;
        if ({en, ready, sleep} !== 3'b001) begin
            bad++;
            $display("FAIL sleep_entry: en/ready/sleep=%b%b%b required 001", en, ready, sleep);
        end
        for (int i = 0; i < 5; i++) step();
        total++;
        if (gated_cnt !== 16'd5) begin
            bad++;
            $display("FAIL sleep_count: gated_cnt=%0d required 5", gated_cnt);
        end
        $display("test_idle_to_sleep done");
    endtask

    task automatic test_wake();
        act = 1'b1;
        step();
        total++;
        if ({en, ready, sleep} !== 3'b100) begin
            bad++;
            $display("FAIL wake_edge1: en/ready/sleep=%b%b%b required 100", en, ready, sleep);
        end
        step();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL wake_edge2: ready=%b required 0", ready);
        end
        step();
        total++;
        if ({en, ready, gated_cnt} !== {1'b1, 1'b1, 16'd5}) begin
            bad++;
            $display("FAIL wake_edge3: en=%b ready=%b cnt=%0d required 1 1 5", en, ready, gated_cnt);
        end
        act = 1'b0;
        $display("test_wake done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 7; i++) step();
        act = 1'b1;
        step();
        act = 1'b0;
        total++;
        if ({en, ready} !== 2'b11) begin
            bad++;
            $display("FAIL act_on_terminal: en=%b ready=%b required 1 1", en, ready);
        end
        for (int i = 1; i <= 7; i++) begin
            step();
            total++;
            if ({en, ready} !== 2'b11) begin
                bad++;
                $display("FAIL idle_restart edge %0d: en=%b ready=%b required 1 1", i, en, ready);
            end
        end
        step();
        total++;
        if ({en, ready} !== 2'b10) begin
            bad++;
            $display("FAIL drain2: en=%b ready=%b required 1 0", en, ready);
        end
        act = 1'b1;
        step();
        act = 1'b0;
        total++;
        if ({en, ready, sleep} !== 3'b110) begin
            bad++;
            $display("FAIL drain_abort: en/ready/sleep=%b%b%b required 110", en, ready, sleep);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_force_on();
        int errs;
        do_reset();
        force_on = 1'b1;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ({en, ready} !== 2'b11) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL force_hold: %0d edges without en&ready, required 0", errs);
        end
        force_on = 1'b0;
        for (int i = 0; i < 9; i++) step();
        total++;
        if (sleep !== 1'b1) begin
            bad++;
            $display("FAIL force_pre_sleep: sleep=%b required 1", sleep);
        end
        force_on = 1'b1;
        step();
        total++;
        if ({en, ready} !== 2'b10) begin
            bad++;
            $display("FAIL force_wake: en=%b ready=%b required 1 0", en, ready);
        end
        step();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL force_no_shortcut: ready=%b required 0", ready);
        end
        step();
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL force_run: ready=%b required 1", ready);
        end
        force_on = 1'b0;
        $display("test_force_on done");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 9; i++) step();
        for (int i = 0; i < 20; i++) step();
        total++;
        if (gated_cnt_s !== 4'd15 || gated_cnt !== 16'd20) begin
            bad++;
            $display("FAIL saturate: cnt4=%0d cnt16=%0d required 15 20", gated_cnt_s, gated_cnt);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({en, ready, sleep, gated_cnt, gated_cnt_s} !== {3'b110, 16'd0, 4'd0}) begin
            bad++;
            $display("FAIL reset_in_sleep: en/ready/sleep=%b%b%b cnt=%0d cnt4=%0d required 110 0 0",
                     en, ready, sleep, gated_cnt, gated_cnt_s);
        end
        $display("test_saturation done");
    endtask

    task automatic test_random();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            act      = ($urandom_range(0, 11) == 0);
            force_on = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 499) == 0);
            step();
            total++;
            if ({en, ready, sleep, gated_cnt, en_s, ready_s, sleep_s, gated_cnt_s} !==
                {m_en, m_ready, m_sleep, exp_g16, m_en, m_ready, m_sleep, exp_g4}) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc %0d: got en/rdy/slp=%b%b%b cnt=%0d cnt4=%0d, required %b%b%b cnt=%0d cnt4=%0d",
                             i, en, ready, sleep, gated_cnt, gated_cnt_s,
                             m_en, m_ready, m_sleep, exp_g16, exp_g4);
            end
        end
        reset = 1'b0; act = 1'b0; force_on = 1'b0;
        $display("test_random done: %0d cycles", 3000);
    endtask

    initial begin
        test_reset();
        test_idle_to_sleep();
        test_wake();
        test_simultaneous();
        test_force_on();
        test_saturation();
        test_random();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
